// File: rtl/sfifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_param_if
// Description : Producer/consumer bundle for the single-clock parameterised
//               FIFO. The master side drives requests and write data; the
//               slave side (the FIFO) returns read data, status and errors.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic                     push;
  logic [DATA_W-1:0]        data_in;
  logic                     pop;
  logic [DATA_W-1:0]        data_out;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;
  logic                     udf;
  logic                     clr_err;

  modport master (
    output push, data_in, pop, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  push, data_in, pop, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface
`default_nettype wire

// File: rtl/sfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_param
// Description : Single-clock FIFO with occupancy count, almost-full/empty
//               thresholds, sticky overflow/underflow flags and a selectable
//               registered or first-word-fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  sfifo_param_if.slave  bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_afull  = c_cw'(AFULL_TH);
  localparam logic [c_cw-1:0] c_aempty = c_cw'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0] count_q,  count_d;
  logic            ovf_q,    ovf_d;
  logic            udf_q,    udf_d;

  logic full, empty;
  logic push_ok, pop_ok;

  // Status flags decode only the registered count, so push acceptance never
  // depends on the same-cycle pop and vice versa.
  assign full    = (count_q == c_depth);
  assign empty   = (count_q == '0);
  assign push_ok = bus.push & ~full;
  assign pop_ok  = bus.pop  & ~empty;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= c_afull);
  assign bus.almost_empty = (count_q <= c_aempty);
  assign bus.count        = count_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + c_aw'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + c_aw'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase

    // A fresh error in the clearing cycle must survive, so set after clear.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.push & full) ovf_d = 1'b1;
    if (bus.pop & empty) udf_d = 1'b1;
  end

  // Control state registers; requests during reset are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents are deliberately left intact across reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; stale slot content while empty.
      assign bus.data_out = mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;

      // Registered read port: loads the head word on an accepted pop only.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
        end else if (pop_ok) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfifo_param
// Description : Directed self-checking bench for sfifo_param, covering a
//               registered-read instance and an FWFT instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sfifo_param_if #(.DATA_W(8), .DEPTH(16)) ifa ();
  sfifo_param_if #(.DATA_W(8), .DEPTH(16)) ifb ();

  sfifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sfifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_dut_fwft (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;

  initial begin
    ifa.push = 1'b1; ifa.pop = 1'b1; ifa.data_in = 8'hFF; ifa.clr_err = 1'b0;
    ifb.push = 1'b0; ifb.pop = 1'b0; ifb.data_in = 8'h00; ifb.clr_err = 1'b0;

    // Reset held two cycles with push/pop active on the registered instance
    rst = 1'b1;
    tick(); tick();
    chk("rst_count", 32'(ifa.count), 0);
    chk("rst_empty", 32'(ifa.empty), 1);
    chk("rst_aempty", 32'(ifa.almost_empty), 1);
    chk("rst_full", 32'(ifa.full), 0);
    chk("rst_afull", 32'(ifa.almost_full), 0);
    chk("rst_ovf", 32'(ifa.ovf), 0);
    chk("rst_udf", 32'(ifa.udf), 0);
    chk("rst_dout", 32'(ifa.data_out), 0);
    chk("rst_b_empty", 32'(ifb.empty), 1);
    rst = 1'b0; ifa.push = 1'b0; ifa.pop = 1'b0;

    // Fill 0x01..0x10, tracking thresholds as count climbs
    for (int i = 1; i <= 16; i++) begin
      ifa.push = 1'b1; ifa.data_in = 8'(i);
      tick();
      chk("fill_count", 32'(ifa.count), 32'(i));
      chk("fill_afull", 32'(ifa.almost_full), 32'(i >= 14));
      chk("fill_aempty", 32'(ifa.almost_empty), 32'(i <= 2));
      chk("fill_full", 32'(ifa.full), 32'(i == 16));
    end

    // Push while full with a simultaneous pop: push dropped, pop done
    ifa.push = 1'b1; ifa.data_in = 8'h11; ifa.pop = 1'b1;
    tick();
    ifa.push = 1'b0; ifa.pop = 1'b0;
    chk("ovf_flag", 32'(ifa.ovf), 1);
    chk("ovf_count", 32'(ifa.count), 15);
    chk("ovf_dout", 32'(ifa.data_out), 32'h01);
    chk("ovf_full", 32'(ifa.full), 0);

    // Drain the remaining 15 words; 0x11 must not appear
    for (int k = 0; k < 15; k++) begin
      ifa.pop = 1'b1;
      tick();
      chk("drain_dout", 32'(ifa.data_out), 32'(2 + k));
      chk("drain_count", 32'(ifa.count), 32'(14 - k));
      chk("drain_afull", 32'(ifa.almost_full), 32'((14 - k) >= 14));
    end
    ifa.pop = 1'b0;
    chk("drain_empty", 32'(ifa.empty), 1);
    chk("ovf_sticky", 32'(ifa.ovf), 1);

    ifa.clr_err = 1'b1;
    tick();
    ifa.clr_err = 1'b0;
    chk("ovf_cleared", 32'(ifa.ovf), 0);

    // Pop on empty with a simultaneous push
    ifa.pop = 1'b1; ifa.push = 1'b1; ifa.data_in = 8'hA5;
    tick();
    ifa.push = 1'b0;
    chk("udf_flag", 32'(ifa.udf), 1);
    chk("udf_count", 32'(ifa.count), 1);
    chk("udf_dout_hold", 32'(ifa.data_out), 32'h10);
    tick();
    chk("udf_next_pop", 32'(ifa.data_out), 32'hA5);
    chk("udf_empty", 32'(ifa.empty), 1);
    ifa.clr_err = 1'b1;
    tick();
    chk("udf_clr_vs_new", 32'(ifa.udf), 1);
    ifa.pop = 1'b0;
    tick();
    ifa.clr_err = 1'b0;
    chk("udf_cleared", 32'(ifa.udf), 0);

    // Prefill 5, then 40 cycles of simultaneous push/pop across wrap
    for (int i = 0; i < 5; i++) begin
      ifa.push = 1'b1; ifa.data_in = 8'(8'h40 + i);
      q.push_back(ifa.data_in);
      tick();
    end
    chk("pre_count", 32'(ifa.count), 5);
    for (int c = 0; c < 40; c++) begin
      ifa.push = 1'b1; ifa.pop = 1'b1; ifa.data_in = 8'(8'h50 + c);
      q.push_back(ifa.data_in);
      exp_d = q.pop_front();
      tick();
      chk("wrap_count", 32'(ifa.count), 5);
      chk("wrap_dout", 32'(ifa.data_out), 32'(exp_d));
    end
    ifa.push = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ifa.pop = 1'b1;
      exp_d = q.pop_front();
      tick();
      chk("wrap_drain", 32'(ifa.data_out), 32'(exp_d));
    end
    ifa.pop = 1'b0;
    chk("wrap_empty", 32'(ifa.empty), 1);

    // FWFT: head word visible right after the push edge
    ifb.push = 1'b1; ifb.data_in = 8'h3C;
    tick();
    ifb.push = 1'b0;
    chk("fwft_first", 32'(ifb.data_out), 32'h3C);
    chk("fwft_nonempty", 32'(ifb.empty), 0);
    for (int i = 1; i < 7; i++) begin
      ifb.push = 1'b1; ifb.data_in = 8'(8'h3C + i);
      tick();
    end
    ifb.push = 1'b0;
    chk("fwft_count7", 32'(ifb.count), 7);
    chk("fwft_head", 32'(ifb.data_out), 32'h3C);
    ifb.pop = 1'b1;
    tick();
    ifb.pop = 1'b0;
    chk("fwft_advance", 32'(ifb.data_out), 32'h3D);
    ifb.push = 1'b1; ifb.data_in = 8'h43;
    tick();
    ifb.push = 1'b0;
    chk("fwft_refill7", 32'(ifb.count), 7);

    // Reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 32'(ifb.count), 0);
    chk("mid_rst_empty", 32'(ifb.empty), 1);
    chk("mid_rst_aempty", 32'(ifb.almost_empty), 1);
    chk("mid_rst_afull", 32'(ifb.almost_full), 0);
    chk("mid_rst_a_dout", 32'(ifa.data_out), 0);

    ifb.push = 1'b1; ifb.data_in = 8'h99;
    ifa.push = 1'b1; ifa.data_in = 8'h77;
    tick();
    ifb.push = 1'b0; ifa.push = 1'b0;
    chk("post_rst_fwft", 32'(ifb.data_out), 32'h99);
    chk("post_rst_count", 32'(ifb.count), 1);
    ifb.pop = 1'b1; ifa.pop = 1'b1;
    tick();
    ifb.pop = 1'b0; ifa.pop = 1'b0;
    chk("post_rst_b_empty", 32'(ifb.empty), 1);
    chk("post_rst_a_dout", 32'(ifa.data_out), 32'h77);
    chk("post_rst_a_empty", 32'(ifa.empty), 1);
    chk("post_rst_udf", 32'(ifb.udf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
